// File: rtl/mem_ctrl.sv
// mem_ctrl: line-to-beat memory controller.
//
// Converts whole-line read/write requests from a hart into a sequence of
// 64-bit memory beats (one outstanding at a time). On the completion
// cycle it strobes h_dv. For a write it also strobes h_inv together with
// the line-aligned address, so that cached copies can be dropped. A simple
// atomic lock (h_amo_req/h_amo_ack) is granted only from IDLE and is
// mirrored on m_lock.
//
// Ports
//   h_clk, h_rst        clock, synchronous active-high reset
//   h_addr              hart byte address (line offset bits ignored)
//   h_rd, h_wr          level requests, held until h_dv (write wins)
//   h_data_out          write line from the hart
//   h_data_in           assembled read line (valid in the h_dv cycle, held)
//   h_dv                one-cycle completion strobe
//   h_inv, h_inv_addr   one-cycle invalidate strobe and its line address
//   h_amo_req/ack       atomic lock request / grant
//   m_req, m_we         memory beat request / write flag
//   m_addr, m_wdata     beat address (8-byte aligned) / write data
//   m_gnt               beat accepted (m_req && m_gnt)
//   m_rvalid, m_rdata   read beat return
//   m_lock              bus lock, mirrors h_amo_ack
module mem_ctrl #(
  parameter int unsigned LINE = 256
) (
  input  logic            h_clk,
  input  logic            h_rst,
  input  logic [63:0]     h_addr,
  input  logic            h_rd,
  input  logic            h_wr,
  input  logic [LINE-1:0] h_data_out,
  output logic [LINE-1:0] h_data_in,
  output logic            h_dv,
  output logic            h_inv,
  output logic [63:0]     h_inv_addr,
  input  logic            h_amo_req,
  output logic            h_amo_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [63:0]     m_addr,
  output logic [63:0]     m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [63:0]     m_rdata,
  output logic            m_lock
);

  localparam int unsigned BEATS = LINE / 64;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  // Mask that clears the byte-within-line offset bits.
  localparam logic [63:0] LINE_MASK = ~64'(LINE / 8 - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]      state_q,    state_d;
  logic [BW-1:0]   beat_q,     beat_d;
  logic [63:0]     base_q,     base_d;
  logic [LINE-1:0] wline_q,    wline_d;
  logic [LINE-1:0] rline_q,    rline_d;
  logic [LINE-1:0] rdata_q,    rdata_d;
  logic [63:0]     inv_addr_q, inv_addr_d;
  logic            is_wr_q,    is_wr_d;
  logic            amo_q,      amo_d;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    wline_d    = wline_q;
    rline_d    = rline_q;
    rdata_d    = rdata_q;
    inv_addr_d = inv_addr_q;
    is_wr_d    = is_wr_q;

    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (h_wr) begin
          base_d  = h_addr & LINE_MASK;
          wline_d = h_data_out;
          is_wr_d = 1'b1;
          state_d = S_WR_ISSUE;
        end else if (h_rd) begin
          base_d  = h_addr & LINE_MASK;
          is_wr_d = 1'b0;
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        if (m_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (m_rvalid) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) rline_d[64*i +: 64] = m_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            // Publish the line including the beat arriving this cycle.
            rdata_d = rline_d;
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_WR_ISSUE: begin
        if (m_gnt) begin
          if (beat_q == LAST_BEAT) begin
            inv_addr_d = base_q;
            state_d    = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DONE: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Lock is only granted from IDLE but may be released in any state.
  always_comb begin
    amo_d = amo_q;
    if (!h_amo_req)            amo_d = 1'b0;
    else if (state_q == S_IDLE) amo_d = 1'b1;
  end

  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      wline_q    <= '0;
      rline_q    <= '0;
      rdata_q    <= '0;
      inv_addr_q <= '0;
      is_wr_q    <= 1'b0;
      amo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      wline_q    <= wline_d;
      rline_q    <= rline_d;
      rdata_q    <= rdata_d;
      inv_addr_q <= inv_addr_d;
      is_wr_q    <= is_wr_d;
      amo_q      <= amo_d;
    end
  end

  always_comb begin
    m_wdata = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat_q == BW'(i)) m_wdata = wline_q[64*i +: 64];
    end
  end

  assign h_dv       = (state_q == S_DONE);
  assign h_inv      = h_dv & is_wr_q;
  assign h_data_in  = rdata_q;
  assign h_inv_addr = inv_addr_q;
  assign h_amo_ack  = amo_q;
  assign m_lock     = amo_q;
  assign m_req      = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE);
  assign m_we       = (state_q == S_WR_ISSUE);
  assign m_addr     = base_q + (64'(beat_q) << 3);

endmodule
